// File: rtl/arb_pkg.sv
// Shared types and helpers for the requestor side of the arbitration interface.
`timescale 1ns/1ps
package arb_pkg;

  localparam int unsigned WEIGHT_W = 8;
  localparam int unsigned TIME_W   = 32;
  localparam int unsigned ID_W     = 8;

  typedef enum logic [1:0] {
    LO  = 2'd0,
    MED = 2'd1,
    HI  = 2'd2
  } priority_t;

  localparam logic [WEIGHT_W-1:0] W_LO  = 8'd1;
  localparam logic [WEIGHT_W-1:0] W_MED = 8'd2;
  localparam logic [WEIGHT_W-1:0] W_HI  = 8'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } agent_state_t;

  // Map a packet priority onto the arbiter weight lane.
  function automatic logic [WEIGHT_W-1:0] prior_to_weight(input priority_t p);
    logic [WEIGHT_W-1:0] w;
    case (p)
      LO:      w = W_LO;
      MED:     w = W_MED;
      HI:      w = W_HI;
      default: w = 8'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Small power-of-two FIFO holding packed {prior, time, data} packet entries.
`timescale 1ns/1ps
module arb_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             push_en;
  logic             pop_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == CW'(0));
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/arb_requestor_agent.sv
// Requestor endpoint: queues timestamped packets, requests the shared
// arbiter, and streams up to QUANTUM packets per grant tenure.
`timescale 1ns/1ps
module arb_requestor_agent
  import arb_pkg::*;
#(
  parameter int unsigned ID      = 0,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned QUANTUM = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  input  priority_t         push_prior,
  output logic              req,
  output logic [7:0]        weight,
  input  logic              grant,
  output logic              tx_valid,
  output logic [7:0]        tx_id,
  output logic [DATA_W-1:0] tx_data,
  output priority_t         tx_prior,
  output logic [31:0]       tx_time,
  output logic              proto_err
);

  localparam int unsigned PRIO_W  = $bits(priority_t);
  localparam int unsigned ENTRY_W = DATA_W + TIME_W + PRIO_W;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int unsigned QCW     = $clog2(QUANTUM + 1);

  agent_state_t        state_q, state_d;
  logic [QCW-1:0]      qcnt_q, qcnt_d;
  logic [TIME_W-1:0]   ts_q;
  logic                req_q;
  logic                proto_q;
  logic                tx_valid_q;
  logic [ID_W-1:0]     tx_id_q;
  logic [DATA_W-1:0]   tx_data_q;
  priority_t           tx_prior_q;
  logic [TIME_W-1:0]   tx_time_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_cnt;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                push_fire;
  logic                pop;
  logic [DATA_W-1:0]   head_data;
  logic [TIME_W-1:0]   head_time;
  priority_t           head_prior;

  assign push_ready = !fifo_full;
  assign push_fire  = push_valid && !fifo_full;

  assign head_data  = fifo_head[DATA_W-1:0];
  assign head_time  = fifo_head[DATA_W +: TIME_W];
  assign head_prior = priority_t'(fifo_head[DATA_W+TIME_W +: PRIO_W]);

  assign weight     = fifo_empty ? 8'd0 : prior_to_weight(head_prior);

  assign req        = req_q;
  assign proto_err  = proto_q;
  assign tx_valid   = tx_valid_q;
  assign tx_id      = tx_id_q;
  assign tx_data    = tx_data_q;
  assign tx_prior   = tx_prior_q;
  assign tx_time    = tx_time_q;

  arb_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push_fire),
    .pop_i   (pop),
    .data_i  ({push_prior, ts_q, push_data}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  // Next-state, quantum counter and pop decision.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        qcnt_d = '0;
        if (!fifo_empty || push_fire) state_d = REQ;
      end
      REQ: begin
        qcnt_d = '0;
        if (grant && !fifo_empty) begin
          pop     = 1'b1;
          qcnt_d  = QCW'(1);
          state_d = (QUANTUM == 1) ? RELEASE : XFER;
        end
      end
      XFER: begin
        if (grant && !fifo_empty) begin
          pop    = 1'b1;
          qcnt_d = qcnt_q + QCW'(1);
          if (qcnt_d == QCW'(QUANTUM)) begin
            state_d = RELEASE;
          end else if (fifo_cnt == CW'(1) && !push_fire) begin
            state_d = IDLE;
          end
        end else begin
          state_d = (!fifo_empty || push_fire) ? REQ : IDLE;
        end
      end
      RELEASE: begin
        qcnt_d  = '0;
        state_d = (!fifo_empty || push_fire) ? REQ : IDLE;
      end
      default: begin
        qcnt_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, timestamp, request, error flag and transmit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      qcnt_q     <= '0;
      ts_q       <= '0;
      req_q      <= 1'b0;
      proto_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_id_q    <= '0;
      tx_data_q  <= '0;
      tx_prior_q <= LO;
      tx_time_q  <= '0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      ts_q       <= ts_q + TIME_W'(1);
      req_q      <= (state_d == REQ) || (state_d == XFER);
      proto_q    <= proto_q | (grant & ~req_q);
      tx_valid_q <= pop;
      tx_id_q    <= ID_W'(ID);
      if (pop) begin
        tx_data_q  <= head_data;
        tx_prior_q <= head_prior;
        tx_time_q  <= head_time;
      end
    end
  end

endmodule

// File: doc/arb_requestor_agent.md
Name: arb_requestor_agent

Overview:
- Requestor-side endpoint of the shared arbitration interface. It is the client that drives one req bit and one weight lane, and consumes the matching grant bit from the FCFS weighted round-robin arbiter.
- Buffers locally produced packets in a small FIFO and timestamps each one on entry.
- Raises req while packets are pending and presents the head packet's priority as a weight.
- While granted, streams packets onto the shared transmit port, up to QUANTUM per tenure, then yields.

Parameters:
- ID, 0, requestor index; driven on tx_id.
- DEPTH, 4, FIFO entries; power of two, >=2.
- DATA_W, 8, packet payload width.
- QUANTUM, 10, maximum packets sent per grant tenure; >=1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- push_valid  in  1  producer offers a packet.
- push_ready  out  1  FIFO can accept; equals !full.
- push_data  in  DATA_W  packet payload.
- push_prior  in  priority_t (2)  packet priority: LO, MED or HI.
- req  out  1  request to the arbiter.
- weight  out  8  weight of the head packet to the arbiter.
- grant  in  1  grant from the arbiter.
- tx_valid  out  1  one-cycle strobe; tx_* fields are valid.
- tx_id  out  8  constant ID.
- tx_data  out  DATA_W  transmitted payload.
- tx_prior  out  priority_t  transmitted priority.
- tx_time  out  32  cycle timestamp captured at push.
- proto_err  out  1  sticky flag: grant seen while req=0.

Behaviour:
- Reset (reset=0, asynchronous): FIFO emptied, contents discarded. State IDLE. All outputs 0 (req, weight, tx_*, proto_err). Timestamp counter 0; quantum counter 0.
- Timestamp: free-running 32-bit cycle counter, wraps 0xFFFFFFFF->0. A push captures the counter value of its accepting edge.
- Push: accepted on an edge where push_valid && push_ready.
  - push_ready is !full only; it ignores a same-cycle pop.
  - Push and pop in the same cycle is legal when the FIFO is non-full, and occupancy is unchanged.
- weight: combinational from the head entry (LO=1, MED=2, HI=3). weight=0 when the FIFO is empty.
- req is registered and equals (state==REQ || state==XFER).
- FSM, with transitions evaluated on each rising edge:
  - IDLE: req=0. Goes to REQ if the FIFO is non-empty, including an entry pushed on this edge, which is visible next cycle.
  - REQ: req=1, quantum counter=0.
    - If grant=1, pop the head onto tx_* with tx_valid=1 next cycle, set count=1, and go to XFER.
    - If grant=0, stay in REQ.
  - XFER: req=1.
    - If grant=1 and the FIFO is non-empty: pop, count++.
    - After the pop, if count==QUANTUM go to RELEASE. Else if the FIFO is empty after the pop (no same-cycle push) go to IDLE. Else stay.
    - If grant=0: no pop. Go to REQ if non-empty, otherwise IDLE.
  - RELEASE: req=0 for exactly one cycle, no pop. Then REQ if non-empty, else IDLE.
- QUANTUM=1 is legal: REQ->RELEASE directly after the single pop.
- Pop latency: grant sampled high at edge n gives tx_valid high during cycle n+1.
- tx_valid is high only for cycles that follow a pop. tx_data/tx_prior/tx_time hold their last values when tx_valid=0.
- proto_err: set on an edge where grant=1 and req=0. Cleared only by reset. Never pops in that case.
- Grant held high in IDLE or RELEASE: no transfer, proto_err set.

Decomposition:
- Package arb_pkg holds:
  - priority_t (LO=0, MED=1, HI=2), shared with the arbiter.
  - Weight constants W_LO=1, W_MED=2, W_HI=3.
  - Function prior_to_weight().
  - State enum agent_state_t {IDLE, REQ, XFER, RELEASE}.
- Sub-module arb_req_fifo stores {data, prior, time}.
  - Parameterised DEPTH and width.
  - Provides full/empty flags, push/pop, and head outputs.
  - Pointer wrap at DEPTH.

Test Plan:
- Reset mid-XFER:
  - Setup: push 3 packets, grant=1; assert reset=0 asynchronously after the first tx_valid.
  - Required: req, tx_valid, weight go 0 immediately. After release, the FIFO is empty and the block stays IDLE with req=0.
- Basic transfer:
  - Setup: push one MED packet data=0x5A at cycle 10; grant=1 when req rises.
  - Required: weight=2 while req=1. tx_valid for exactly 1 cycle, tx_data=0x5A, tx_time=10, tx_id=ID. Then req=0 and state IDLE.
- Quantum limit:
  - Setup: QUANTUM=2, DEPTH=4; 4 packets queued; grant held at 1.
  - Required: 2 tx_valid pulses, req low for exactly 1 cycle, req re-asserted, 2 more pulses, then IDLE. Output order equals push order.
- FIFO full:
  - Setup: DEPTH=4, grant=0, push 5 packets back-to-back.
  - Required: push_ready drops after the 4th accept and the 5th is not accepted. weight equals the first packet's priority; HI gives 3.
- Grant loss:
  - Setup: 3 packets queued; grant high 1 cycle after req, then low.
  - Required: exactly 1 tx_valid, state back to REQ with req=1, and weight follows the new head.
- Protocol error:
  - Setup: FIFO empty, grant=1 for one cycle.
  - Required: proto_err=1 and stays 1, no tx_valid, req=0.
